// File: rtl/imm_fetch_ctrl_if.sv
// Bundle of the start/memory/result signals of imm_fetch_ctrl.
// The master modport is the controller side; the slave modport is decode, memory and consumer.
interface imm_fetch_ctrl_if #(
  parameter int ADDR_W = 20
);
  logic              start;
  logic [1:0]        mode;
  logic [ADDR_W-1:0] base_addr;
  logic              busy;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [7:0]        mem_rdata;
  logic [19:0]       imm;
  logic              imm_valid;
  logic              imm_ready;
  logic              err;

  modport master (
    input  start, mode, base_addr, mem_ack, mem_rdata, imm_ready,
    output busy, mem_req, mem_addr, imm, imm_valid, err
  );

  modport slave (
    output start, mode, base_addr, mem_ack, mem_rdata, imm_ready,
    input  busy, mem_req, mem_addr, imm, imm_valid, err
  );
endinterface

// File: rtl/imm_fetch_ctrl.sv
// Fetches 1 or 3 bytes over req/ack and builds a 20-bit immediate with a valid/ready result.
// Define IMM_SIGN_EXT_EN to make mode 1 sign-extend; otherwise mode 1 zero-extends like mode 0.
module imm_fetch_ctrl #(
  parameter int ADDR_W      = 20,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  imm_fetch_ctrl_if.master bus
);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;

  state_t            state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [7:0]        tmo_q, tmo_d;
  logic [1:0]        mode_q, mode_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [7:0]        b0_q, b0_d, b1_q, b1_d;
  logic [3:0]        b2_q, b2_d;
  logic              busy_q, busy_d;
  logic              mem_req_q, mem_req_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [19:0]       imm_q, imm_d;
  logic              imm_valid_q, imm_valid_d;
  logic              err_q, err_d;
  logic [1:0]        last_cnt;

  function automatic logic [19:0] assemble(input logic [1:0] m, input logic [7:0] lo,
                                           input logic [7:0] mid, input logic [3:0] hi);
    logic [19:0] r;
    r = {12'b0, lo};
    if (m == 2'd2) r = {hi, mid, lo};
`ifdef IMM_SIGN_EXT_EN
    else if (m == 2'd1) r = {{12{lo[7]}}, lo};
`endif
    return r;
  endfunction

  assign last_cnt = (mode_q == 2'd2) ? 2'd2 : 2'd0;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    tmo_d       = tmo_q;
    mode_d      = mode_q;
    base_d      = base_q;
    b0_d        = b0_q;
    b1_d        = b1_q;
    b2_d        = b2_q;
    mem_req_d   = mem_req_q;
    mem_addr_d  = mem_addr_q;
    imm_d       = imm_q;
    imm_valid_d = imm_valid_q;
    err_d       = err_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (bus.mode != 2'd3) begin
            state_d    = FETCH;
            mode_d     = bus.mode;
            base_d     = bus.base_addr;
            cnt_d      = 2'd0;
            tmo_d      = 8'd0;
            mem_req_d  = 1'b1;
            mem_addr_d = bus.base_addr;
          end else begin
            state_d     = HOLD;
            imm_d       = 20'd0;
            err_d       = 1'b1;
            imm_valid_d = 1'b1;
          end
        end
      end
      FETCH: begin
        if (bus.mem_ack) begin
          tmo_d = 8'd0;
          case (cnt_q)
            2'd0:    b0_d = bus.mem_rdata;
            2'd1:    b1_d = bus.mem_rdata;
            default: b2_d = bus.mem_rdata[3:0];
          endcase
          if (cnt_q == last_cnt) begin
            state_d     = HOLD;
            mem_req_d   = 1'b0;
            imm_valid_d = 1'b1;
            err_d       = 1'b0;
            imm_d       = assemble(mode_q, b0_d, b1_d, b2_d);
          end else begin
            cnt_d      = cnt_q + 2'd1;
            mem_addr_d = base_q + ADDR_W'(cnt_q) + ADDR_W'(1);
          end
        end else if (tmo_q == 8'(TIMEOUT_CYC - 1)) begin
          state_d     = HOLD;
          mem_req_d   = 1'b0;
          imm_valid_d = 1'b1;
          err_d       = 1'b1;
          imm_d       = 20'd0;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      HOLD: begin
        if (bus.imm_ready) begin
          state_d     = IDLE;
          imm_valid_d = 1'b0;
          err_d       = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= 2'd0;
      tmo_q       <= 8'd0;
      mode_q      <= 2'd0;
      base_q      <= '0;
      b0_q        <= 8'd0;
      b1_q        <= 8'd0;
      b2_q        <= 4'd0;
      busy_q      <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      imm_q       <= 20'd0;
      imm_valid_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      tmo_q       <= tmo_d;
      mode_q      <= mode_d;
      base_q      <= base_d;
      b0_q        <= b0_d;
      b1_q        <= b1_d;
      b2_q        <= b2_d;
      busy_q      <= busy_d;
      mem_req_q   <= mem_req_d;
      mem_addr_q  <= mem_addr_d;
      imm_q       <= imm_d;
      imm_valid_q <= imm_valid_d;
      err_q       <= err_d;
    end
  end

  assign bus.busy      = busy_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.imm       = imm_q;
  assign bus.imm_valid = imm_valid_q;
  assign bus.err       = err_q;

endmodule

// File: tb/tb_imm_fetch_ctrl.sv
// Directed self-checking bench for imm_fetch_ctrl; mode-1 expectations follow IMM_SIGN_EXT_EN.
module tb_imm_fetch_ctrl;

  logic clk;
  logic rst_n;
  int   checkCount;
  int   errorCount;

  imm_fetch_ctrl_if #(.ADDR_W(20)) bus ();

  imm_fetch_ctrl #(.ADDR_W(20), .TIMEOUT_CYC(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    if (obs !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [1:0] m, input logic [19:0] base);
    bus.start     = 1'b1;
    bus.mode      = m;
    bus.base_addr = base;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic ackByte(input string tag, input logic [19:0] expAddr, input logic [7:0] data,
                         input int delay);
    for (int i = 0; i < delay; i++) begin
      checkOutput({tag, " req held"}, 32'(bus.mem_req), 32'd1);
      checkOutput({tag, " addr wait"}, 32'(bus.mem_addr), 32'(expAddr));
      tick();
    end
    checkOutput({tag, " req"}, 32'(bus.mem_req), 32'd1);
    checkOutput({tag, " addr"}, 32'(bus.mem_addr), 32'(expAddr));
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = data;
    tick();
    bus.mem_ack = 1'b0;
  endtask

  task automatic checkResult(input string tag, input logic [19:0] expImm, input logic expErr);
    checkOutput({tag, " valid"}, 32'(bus.imm_valid), 32'd1);
    checkOutput({tag, " imm"}, 32'(bus.imm), 32'(expImm));
    checkOutput({tag, " err"}, 32'(bus.err), 32'(expErr));
    checkOutput({tag, " req off"}, 32'(bus.mem_req), 32'd0);
    checkOutput({tag, " busy"}, 32'(bus.busy), 32'd1);
  endtask

  task automatic releaseResult(input string tag);
    bus.imm_ready = 1'b1;
    tick();
    bus.imm_ready = 1'b0;
    checkOutput({tag, " valid drop"}, 32'(bus.imm_valid), 32'd0);
    checkOutput({tag, " err drop"}, 32'(bus.err), 32'd0);
    checkOutput({tag, " idle"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    logic [19:0] expMode1;
    logic [19:0] heldImm;
    int          reqCycles;

    checkCount    = 0;
    errorCount    = 0;
    rst_n         = 1'b0;
    bus.start     = 1'b0;
    bus.mode      = 2'd0;
    bus.base_addr = 20'd0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = 8'd0;
    bus.imm_ready = 1'b0;
    tick();
    tick();
    checkOutput("rst busy", 32'(bus.busy), 32'd0);
    checkOutput("rst req", 32'(bus.mem_req), 32'd0);
    checkOutput("rst addr", 32'(bus.mem_addr), 32'd0);
    checkOutput("rst imm", 32'(bus.imm), 32'd0);
    checkOutput("rst valid", 32'(bus.imm_valid), 32'd0);
    checkOutput("rst err", 32'(bus.err), 32'd0);
    rst_n = 1'b1;
    tick();

    $display("[TB] stray ack while idle");
    bus.mem_ack = 1'b1;
    tick();
    bus.mem_ack = 1'b0;
    checkOutput("idle ack busy", 32'(bus.busy), 32'd0);
    checkOutput("idle ack valid", 32'(bus.imm_valid), 32'd0);

    $display("[TB] mode0 single byte");
    applyStimulus(2'd0, 20'h00010);
    checkOutput("m0 busy", 32'(bus.busy), 32'd1);
    ackByte("m0", 20'h00010, 8'hA5, 0);
    checkResult("m0", 20'h000A5, 1'b0);
    releaseResult("m0");

    $display("[TB] mode1 single byte");
`ifdef IMM_SIGN_EXT_EN
    expMode1 = 20'hFFF80;
`else
    expMode1 = 20'h00080;
`endif
    applyStimulus(2'd1, 20'h00400);
    ackByte("m1", 20'h00400, 8'h80, 0);
    checkResult("m1", expMode1, 1'b0);
    releaseResult("m1");

    $display("[TB] mode2 wrap with delayed acks");
    applyStimulus(2'd2, 20'hFFFFF);
    ackByte("m2 b0", 20'hFFFFF, 8'h34, 2);
    ackByte("m2 b1", 20'h00000, 8'h12, 2);
    ackByte("m2 b2", 20'h00001, 8'hF7, 2);
    checkResult("m2", 20'h71234, 1'b0);
    releaseResult("m2");

    $display("[TB] timeout");
    applyStimulus(2'd0, 20'h00020);
    reqCycles = 0;
    for (int i = 0; i < 40; i++) begin
      if (!bus.mem_req) break;
      reqCycles++;
      tick();
    end
    checkOutput("tmo req cycles", 32'(reqCycles), 32'd16);
    checkResult("tmo", 20'h00000, 1'b1);
    releaseResult("tmo");

    $display("[TB] illegal mode");
    applyStimulus(2'd3, 20'h00030);
    checkResult("ill", 20'h00000, 1'b1);
    tick();
    checkOutput("ill req never", 32'(bus.mem_req), 32'd0);
    releaseResult("ill");

    $display("[TB] back-pressure");
    applyStimulus(2'd0, 20'h00040);
    ackByte("bp", 20'h00040, 8'h5C, 0);
    heldImm = 20'h0005C;
    for (int i = 0; i < 5; i++) begin
      bus.start     = 1'b1;
      bus.mode      = 2'd0;
      bus.base_addr = 20'h00777;
      tick();
      checkOutput("bp imm stable", 32'(bus.imm), 32'(heldImm));
      checkOutput("bp valid held", 32'(bus.imm_valid), 32'd1);
      checkOutput("bp busy", 32'(bus.busy), 32'd1);
      checkOutput("bp no req", 32'(bus.mem_req), 32'd0);
    end
    bus.imm_ready = 1'b1;
    tick();
    bus.imm_ready = 1'b0;
    bus.start     = 1'b0;
    checkOutput("bp handshake start ignored", 32'(bus.mem_req), 32'd0);
    checkOutput("bp idle", 32'(bus.busy), 32'd0);
    applyStimulus(2'd0, 20'h00123);
    checkOutput("bp restart req", 32'(bus.mem_req), 32'd1);
    checkOutput("bp restart addr", 32'(bus.mem_addr), 32'h00123);
    ackByte("bp2", 20'h00123, 8'h07, 0);
    checkResult("bp2", 20'h00007, 1'b0);
    releaseResult("bp2");

    $display("[TB] reset mid-fetch");
    applyStimulus(2'd2, 20'h00200);
    ackByte("rs b0", 20'h00200, 8'h11, 0);
    checkOutput("rs addr next", 32'(bus.mem_addr), 32'h00201);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checkOutput("rs busy", 32'(bus.busy), 32'd0);
    checkOutput("rs req", 32'(bus.mem_req), 32'd0);
    checkOutput("rs addr", 32'(bus.mem_addr), 32'd0);
    checkOutput("rs imm", 32'(bus.imm), 32'd0);
    checkOutput("rs valid", 32'(bus.imm_valid), 32'd0);
    checkOutput("rs err", 32'(bus.err), 32'd0);
    applyStimulus(2'd0, 20'h00050);
    ackByte("post", 20'h00050, 8'h3C, 1);
    checkResult("post", 20'h0003C, 1'b0);
    releaseResult("post");

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
